// File: rtl/eth_tx_frame_arbiter_if.sv
// Frame-source and MAC-side AXI-stream bundle for eth_tx_frame_arbiter.
// master: arbiter view; slave: sources plus MAC (testbench / surrounding fabric).
interface eth_tx_frame_arbiter_if #(
    parameter int unsigned NUM_SRC = 3
);
    logic [NUM_SRC-1:0]    s_tvalid;
    logic [NUM_SRC-1:0]    s_tready;
    logic [NUM_SRC-1:0]    s_tlast;
    logic [8*NUM_SRC-1:0]  s_tkeep;
    logic [64*NUM_SRC-1:0] s_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [7:0]            m_tkeep;
    logic [63:0]           m_tdata;
    logic                  m_tuser;

    modport master (
        input  s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, m_tuser
    );

    modport slave (
        output s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, m_tuser
    );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Packet-level round-robin arbiter with burst allowance, inter-frame gap and stall abort.
// Optional per-source frame / abort counters when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_frame_arbiter #(
    parameter int unsigned NUM_SRC       = 3,
    parameter int unsigned BURST_MAX     = 4,
    parameter int unsigned IFG_CYCLES    = 2,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic                     eth_clk,
    input  logic                     eth_rst_n,
    eth_tx_frame_arbiter_if.master   bus,
    output logic [NUM_SRC-1:0]       grant_o,
    output logic                     abort_pulse_o
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [32*NUM_SRC-1:0]    frame_cnt_o,
    output logic [15:0]              abort_cnt_o
`endif
);
    localparam int unsigned PTR_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [7:0]  STALL_LIMIT = 8'(STALL_TIMEOUT - 1);
    localparam logic [3:0]  GAP_LAST    = 4'(IFG_CYCLES - 1);
    localparam logic [4:0]  BURST_LIM   = 5'(BURST_MAX);

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_PASS,
        ARB_GAP,
        ARB_ABORT,
        ARB_DRAIN
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [7:0]         stall_cnt_q, stall_cnt_d;

    logic [7:0]         src_keep [NUM_SRC];
    logic [63:0]        src_data [NUM_SRC];
    logic               sel_valid;
    logic               sel_last;
    logic [PTR_W-1:0]   next_ptr;
    logic               others_req;
    logic               scan_hit;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   cand;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_keep[i] = bus.s_tkeep[8*i +: 8];
            src_data[i] = bus.s_tdata[64*i +: 64];
        end
    end

    assign sel_valid  = bus.s_tvalid[sel_q];
    assign sel_last   = bus.s_tlast[sel_q];
    assign next_ptr   = (sel_q == PTR_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;
    // grant_q is the one-hot of sel while a frame is owned
    assign others_req = |(bus.s_tvalid & ~grant_q);
    assign grant_o    = grant_q;

    always_comb begin
        scan_hit = 1'b0;
        scan_idx = rr_ptr_q;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!scan_hit && bus.s_tvalid[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        sel_d         = sel_q;
        grant_d       = grant_q;
        burst_cnt_d   = burst_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        bus.m_tvalid  = 1'b0;
        bus.m_tlast   = 1'b0;
        bus.m_tkeep   = '0;
        bus.m_tdata   = '0;
        bus.m_tuser   = 1'b0;
        bus.s_tready  = '0;
        abort_pulse_o = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (scan_hit) begin
                    sel_d       = scan_idx;
                    grant_d     = NUM_SRC'(1) << scan_idx;
                    stall_cnt_d = '0;
                    state_d     = ARB_PASS;
                end
            end

            ARB_PASS: begin
                bus.m_tvalid = sel_valid;
                bus.m_tlast  = sel_last;
                bus.m_tkeep  = src_keep[sel_q];
                bus.m_tdata  = src_data[sel_q];
                bus.s_tready = grant_q & {NUM_SRC{bus.m_tready}};
                if (sel_valid) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == STALL_LIMIT) begin
                    stall_cnt_d = '0;
                    state_d     = ARB_ABORT;
                end else begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
                if (sel_valid && bus.m_tready && sel_last) begin
                    // Staying on sel without contention does not consume burst allowance
                    if (!others_req) begin
                        burst_cnt_d = '0;
                        rr_ptr_d    = sel_q;
                    end else if ({1'b0, burst_cnt_q} + 5'd1 < BURST_LIM) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                        rr_ptr_d    = sel_q;
                    end else begin
                        burst_cnt_d = '0;
                        rr_ptr_d    = next_ptr;
                    end
                    gap_cnt_d = '0;
                    if (IFG_CYCLES == 0) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ARB_GAP;
                    end
                end
            end

            ARB_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    grant_d   = '0;
                    state_d   = ARB_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            ARB_ABORT: begin
                bus.m_tvalid = 1'b1;
                bus.m_tlast  = 1'b1;
                bus.m_tuser  = 1'b1;
                bus.m_tkeep  = 8'hFF;
                if (bus.m_tready) begin
                    abort_pulse_o = 1'b1;
                    state_d       = ARB_DRAIN;
                end
            end

            ARB_DRAIN: begin
                bus.s_tready = grant_q;
                if (sel_valid && sel_last) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                    gap_cnt_d   = '0;
                    if (IFG_CYCLES == 0) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ARB_GAP;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [32*NUM_SRC-1:0] frame_cnt_q;
    logic [15:0]           abort_cnt_q;
    logic                  pass_last;

    assign pass_last = (state_q == ARB_PASS) && sel_valid && bus.m_tready && sel_last;

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (pass_last && (sel_q == PTR_W'(i)) && (frame_cnt_q[32*i +: 32] != '1)) begin
                    frame_cnt_q[32*i +: 32] <= frame_cnt_q[32*i +: 32] + 32'd1;
                end
            end
            if (abort_pulse_o && (abort_cnt_q != '1)) begin
                abort_cnt_q <= abort_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign abort_cnt_o = abort_cnt_q;
`endif
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized self-checking bench for eth_tx_frame_arbiter against a frame-level reference model.
// Stats outputs are checked when ETH_TX_ARB_STATS_EN is defined.
module tb_eth_tx_frame_arbiter;
    localparam int unsigned NUM_SRC       = 3;
    localparam int unsigned BURST_MAX     = 2;
    localparam int unsigned IFG_CYCLES    = 2;
    localparam int unsigned STALL_TIMEOUT = 64;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  delay;
    } beat_t;

    logic eth_clk   = 1'b0;
    logic eth_rst_n = 1'b0;
    logic [NUM_SRC-1:0] grant_o;
    logic               abort_pulse_o;
`ifdef ETH_TX_ARB_STATS_EN
    logic [32*NUM_SRC-1:0] frame_cnt_o;
    logic [15:0]           abort_cnt_o;
`endif

    eth_tx_frame_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

    always #5 eth_clk = ~eth_clk;

    eth_tx_frame_arbiter #(
        .NUM_SRC       (NUM_SRC),
        .BURST_MAX     (BURST_MAX),
        .IFG_CYCLES    (IFG_CYCLES),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) dut (
        .eth_clk       (eth_clk),
        .eth_rst_n     (eth_rst_n),
        .bus           (bus),
        .grant_o       (grant_o),
        .abort_pulse_o (abort_pulse_o)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .frame_cnt_o   (frame_cnt_o),
        .abort_cnt_o   (abort_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Source-side stimulus and the reference copy of every beat
    beat_t drv_q [NUM_SRC][$];
    beat_t exp_q [NUM_SRC][$];
    int    wait_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] hs_q;
    int    ready_mode;

    // Reference model of arbitration at frame granularity
    int owner, gap_left, low_run, rr, burst;
    bit killed, flushing;
    int frames_done [NUM_SRC];
    int aborts_seen;
    int grant_log [$];

    task automatic reset_model();
        owner = -1; gap_left = 0; low_run = 0; rr = 0; burst = 0;
        killed = 0; flushing = 0; aborts_seen = 0; hs_q = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            wait_cnt[i]    = 0;
            frames_done[i] = 0;
        end
    endtask

    task automatic enq_frame(input int src, input int len, input int stall_beat,
                             input int stall_len, input int first_delay, input bit gaps);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = {$urandom, $urandom};
            b.keep  = 8'($urandom) | 8'h01;
            b.last  = (k == len - 1);
            if (k == stall_beat)  b.delay = 8'(stall_len);
            else if (k == 0)      b.delay = 8'(first_delay);
            else if (gaps)        b.delay = 8'($urandom_range(0, 3));
            else                  b.delay = 8'd0;
            if (drv_q[src].size() == 0) wait_cnt[src] = b.delay;
            drv_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        logic [NUM_SRC-1:0]    v, l;
        logic [8*NUM_SRC-1:0]  k;
        logic [64*NUM_SRC-1:0] d;
        v = '0; l = '0; k = '0; d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (drv_q[i].size() > 0 && wait_cnt[i] == 0) begin
                v[i]          = 1'b1;
                l[i]          = drv_q[i][0].last;
                k[8*i +: 8]   = drv_q[i][0].keep;
                d[64*i +: 64] = drv_q[i][0].data;
            end
        end
        bus.s_tvalid = v;
        bus.s_tlast  = l;
        bus.s_tkeep  = k;
        bus.s_tdata  = d;
    endtask

    task automatic advance_drivers();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs_q[i] && drv_q[i].size() > 0) begin
                void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) wait_cnt[i] = drv_q[i][0].delay;
            end else if (drv_q[i].size() > 0 && wait_cnt[i] > 0) begin
                wait_cnt[i]--;
            end
        end
    endtask

    task automatic frame_end();
        if (IFG_CYCLES == 0) owner = -1;
        else gap_left = IFG_CYCLES;
    endtask

    task automatic model_step();
        logic [NUM_SRC-1:0] sv, sr, eg, er;
        beat_t b;
        sv   = bus.s_tvalid;
        sr   = bus.s_tready;
        hs_q = sv & sr;
        eg   = '0;
        if (owner >= 0) eg[owner] = 1'b1;
        check_eq("grant", grant_o, eg);
        if (!killed) check_eq("m_tuser", bus.m_tuser, 0);
        if (owner < 0) begin
            check_eq("idle_m_tvalid", bus.m_tvalid, 0);
            check_eq("idle_s_tready", sr, 0);
            check_eq("idle_abort", abort_pulse_o, 0);
            for (int k = 0; k < NUM_SRC; k++) begin
                int idx;
                idx = (rr + k) % NUM_SRC;
                if (sv[idx]) begin
                    owner   = idx;
                    low_run = 0;
                    grant_log.push_back(idx);
                    break;
                end
            end
        end else if (gap_left > 0) begin
            check_eq("gap_m_tvalid", bus.m_tvalid, 0);
            check_eq("gap_s_tready", sr, 0);
            check_eq("gap_abort", abort_pulse_o, 0);
            gap_left--;
            if (gap_left == 0) owner = -1;
        end else if (killed) begin
            check_eq("abort_m_tvalid", bus.m_tvalid, 1);
            check_eq("abort_m_tlast", bus.m_tlast, 1);
            check_eq("abort_m_tuser", bus.m_tuser, 1);
            check_eq("abort_m_tkeep", bus.m_tkeep, 8'hFF);
            check_eq("abort_m_tdata", bus.m_tdata, 0);
            check_eq("abort_s_tready", sr, 0);
            check_eq("abort_pulse", abort_pulse_o, bus.m_tready);
            if (bus.m_tready) begin
                killed   = 0;
                flushing = 1;
                aborts_seen++;
            end
        end else if (flushing) begin
            er = '0;
            er[owner] = 1'b1;
            check_eq("drain_m_tvalid", bus.m_tvalid, 0);
            check_eq("drain_s_tready", sr, er);
            check_eq("drain_abort", abort_pulse_o, 0);
            if (sv[owner] && exp_q[owner].size() > 0) begin
                b = exp_q[owner].pop_front();
                if (b.last) begin
                    rr       = (owner + 1) % NUM_SRC;
                    burst    = 0;
                    flushing = 0;
                    frame_end();
                end
            end
        end else begin
            er = '0;
            er[owner] = bus.m_tready;
            check_eq("pass_m_tvalid", bus.m_tvalid, sv[owner]);
            check_eq("pass_s_tready", sr, er);
            check_eq("pass_abort", abort_pulse_o, 0);
            if (bus.m_tvalid && exp_q[owner].size() > 0) begin
                b = exp_q[owner][0];
                check_eq("pass_m_tdata", bus.m_tdata, b.data);
                check_eq("pass_m_tkeep", bus.m_tkeep, b.keep);
                check_eq("pass_m_tlast", bus.m_tlast, b.last);
            end
            if (sv[owner]) low_run = 0;
            else if (low_run == STALL_TIMEOUT - 1) killed = 1;
            else low_run++;
            if (sv[owner] && bus.m_tready && exp_q[owner].size() > 0) begin
                b = exp_q[owner].pop_front();
                if (b.last) begin
                    frames_done[owner]++;
                    if ((sv & ~er) == '0) begin
                        burst = 0;
                        rr    = owner;
                    end else if (burst + 1 < BURST_MAX) begin
                        burst++;
                        rr = owner;
                    end else begin
                        burst = 0;
                        rr    = (owner + 1) % NUM_SRC;
                    end
                    frame_end();
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge eth_clk);
        model_step();
        @(posedge eth_clk);
        #1;
        advance_drivers();
        drive_inputs();
        case (ready_mode)
            0:       bus.m_tready = 1'b1;
            1:       bus.m_tready = ~bus.m_tready;
            default: bus.m_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    function automatic bit busy();
        for (int i = 0; i < NUM_SRC; i++)
            if (drv_q[i].size() > 0 || exp_q[i].size() > 0) return 1'b1;
        return owner >= 0;
    endfunction

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        check_eq({tag, "_completed"}, (n < budget), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_grant"}, grant_o, 0);
        check_eq({tag, "_m_tvalid"}, bus.m_tvalid, 0);
        check_eq({tag, "_m_tlast"}, bus.m_tlast, 0);
        check_eq({tag, "_m_tkeep"}, bus.m_tkeep, 0);
        check_eq({tag, "_m_tdata"}, bus.m_tdata, 0);
        check_eq({tag, "_m_tuser"}, bus.m_tuser, 0);
        check_eq({tag, "_s_tready"}, bus.s_tready, 0);
        check_eq({tag, "_abort"}, abort_pulse_o, 0);
    endtask

    initial begin
        int mark, ab0;
        int fair_exp [12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};

        reset_model();
        ready_mode   = 0;
        bus.m_tready = 1'b0;
        drive_inputs();
        #23;
        check_outputs_zero("reset");
        @(posedge eth_clk);
        #2 eth_rst_n = 1'b1;

        // Fairness: every source holds four 1-beat frames
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < NUM_SRC; s++) enq_frame(s, 1, -1, 0, 0, 0);
        drive_inputs();
        run_until_done("fair", 400);
        for (int i = 0; i < 12; i++)
            check_eq("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, fair_exp[i]);

        // Single 6-beat frame from source 1
        mark = grant_log.size();
        enq_frame(1, 6, -1, 0, 0, 0);
        drive_inputs();
        run_until_done("single", 100);
        check_eq("single_grant", (mark < grant_log.size()) ? grant_log[mark] : -1, 1);

        // Backpressure on a 4-beat source-0 frame
        ready_mode   = 1;
        bus.m_tready = 1'b1;
        mark = grant_log.size();
        enq_frame(0, 4, -1, 0, 0, 0);
        drive_inputs();
        run_until_done("bp", 100);
        check_eq("bp_grant", (mark < grant_log.size()) ? grant_log[mark] : -1, 0);

        // Stall abort on source 2, sources 0/1 start requesting mid-stall
        ready_mode = 0;
        mark = grant_log.size();
        ab0  = aborts_seen;
        enq_frame(2, 5, 2, STALL_TIMEOUT, 0, 0);
        enq_frame(1, 2, -1, 0, 10, 0);
        enq_frame(0, 2, -1, 0, 10, 0);
        drive_inputs();
        run_until_done("stall", 600);
        check_eq("stall_abort_count", aborts_seen - ab0, 1);
        check_eq("stall_first", (mark < grant_log.size()) ? grant_log[mark] : -1, 2);
        check_eq("stall_next", (mark + 1 < grant_log.size()) ? grant_log[mark + 1] : -1, 0);

        // Randomized traffic, including stalls straddling the timeout
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int src, len;
            src = $urandom_range(0, NUM_SRC - 1);
            len = $urandom_range(1, 8);
            if (len > 1 && $urandom_range(0, 7) == 0)
                enq_frame(src, len, $urandom_range(1, len - 1),
                          STALL_TIMEOUT - 1 + $urandom_range(0, 1), $urandom_range(0, 3), 1);
            else
                enq_frame(src, len, -1, 0, $urandom_range(0, 3), 1);
        end
        drive_inputs();
        run_until_done("random", 20000);

        // Reset during beat 3 of a source-2 frame
        ready_mode = 0;
        enq_frame(2, 6, -1, 0, 0, 0);
        drive_inputs();
        begin
            int n;
            n = 0;
            while (exp_q[2].size() > 4 && n < 50) begin
                cycle();
                n++;
            end
            check_eq("rst_mid_reached", (n < 50), 1);
        end
        #2 eth_rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        reset_model();
        drive_inputs();
        @(posedge eth_clk);
        #2 eth_rst_n = 1'b1;
        mark = grant_log.size();
        enq_frame(1, 3, -1, 0, 0, 0);
        enq_frame(2, 4, 1, STALL_TIMEOUT, 0, 0);
        drive_inputs();
        run_until_done("post_rst", 600);
        check_eq("post_rst_first", (mark < grant_log.size()) ? grant_log[mark] : -1, 1);

        for (int r = 0; r < 5; r++) enq_frame(0, 2, -1, 0, 0, 0);
        for (int r = 0; r < 2; r++) enq_frame(1, 3, -1, 0, 0, 0);
        drive_inputs();
        run_until_done("stats_traffic", 600);
        check_eq("post_rst_aborts", aborts_seen, 1);
`ifdef ETH_TX_ARB_STATS_EN
        check_eq("frame_cnt_0", frame_cnt_o[31:0], 5);
        check_eq("frame_cnt_1", frame_cnt_o[63:32], 3);
        check_eq("frame_cnt_2", frame_cnt_o[95:64], 0);
        check_eq("abort_cnt", abort_cnt_o, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Packet-level arbiter between the 64-bit Ethernet TX frame sources and the single MAC TX AXI-stream.
- Sources: the encapsulated-TLP stream, the NetTLP command stream and the PCIe-config reply stream, each already carrying complete Eth+IP+UDP frames.
- Grants one source per frame using round-robin with a per-grant burst allowance, and enforces a minimum idle gap between frames.
- A stall watchdog aborts frames whose source stops mid-frame, so the MAC never hangs.

Parameters:
- NUM_SRC, 3: number of source streams; source 0 is the TLP path.
- BURST_MAX, 4: maximum back-to-back frames granted to one source while others request (1..15).
- IFG_CYCLES, 2: idle eth_clk cycles forced after each frame's last beat (0..15).
- STALL_TIMEOUT, 64: consecutive cycles with selected s_tvalid low mid-frame before abort (2..255).

Ports:
- eth_clk  in  1  Ethernet TX clock
- eth_rst_n  in  1  asynchronous active-low reset
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tlast  in  NUM_SRC  per-source last beat
- s_tkeep  in  8*NUM_SRC  per-source byte keep; source i at [8i+7:8i]
- s_tdata  in  64*NUM_SRC  per-source data; source i at [64i+63:64i]
- m_tvalid  out  1  to MAC
- m_tready  in  1  from MAC
- m_tlast  out  1  to MAC
- m_tkeep  out  8  to MAC
- m_tdata  out  64  to MAC
- m_tuser  out  1  bad-frame marker to MAC; 1 only on an abort beat
- grant  out  NUM_SRC  one-hot currently selected source; 0 when idle
- abort_pulse  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: one clock, eth_clk; reset is asynchronous, active-low (eth_rst_n). During reset all outputs are 0, state ARB_IDLE, rr_ptr=0, burst_cnt=0, gap_cnt=0, stall_cnt=0.
- States: ARB_IDLE, ARB_PASS, ARB_GAP, ARB_ABORT, ARB_DRAIN.

ARB_IDLE:
- Scans s_tvalid starting at rr_ptr, wrapping modulo NUM_SRC. The first asserted source is registered as sel and drives grant; next state ARB_PASS.
- No s_tready asserted and m_tvalid=0 in this state. Latency from s_tvalid rising to first m_tvalid is 1 cycle.

ARB_PASS:
- m_tvalid/m_tlast/m_tkeep/m_tdata are combinational from source sel. s_tready[sel]=m_tready; every other s_tready=0; m_tuser=0.
- Handshake = m_tvalid & m_tready.
- A handshake with tlast ends the frame:
  - If burst_cnt+1 < BURST_MAX: burst_cnt increments and rr_ptr stays at sel.
  - Otherwise burst_cnt clears and rr_ptr becomes (sel+1) mod NUM_SRC.
  - Next state is ARB_GAP, or ARB_IDLE when IFG_CYCLES=0.
- When rr_ptr advances to a new source, burst_cnt is 0.
- A stay at the same sel is not a burst if no other source had s_tvalid at the time of the tlast handshake: burst_cnt clears and rr_ptr stays at sel.
- stall_cnt increments each cycle s_tvalid[sel]=0 in ARB_PASS and clears on any cycle it is 1. m_tready low does not count as a stall.
- stall_cnt reaching STALL_TIMEOUT-1 with s_tvalid[sel] still 0 moves the state to ARB_ABORT.

ARB_GAP:
- gap_cnt counts 0..IFG_CYCLES-1 with m_tvalid=0 and all s_tready=0, then ARB_IDLE. grant holds its value until ARB_IDLE.

ARB_ABORT:
- Drives m_tvalid=1, m_tlast=1, m_tuser=1, m_tkeep=8'hFF, m_tdata=0. s_tready all 0.
- On m_ready handshake: abort_pulse=1 for that cycle, then ARB_DRAIN.

ARB_DRAIN:
- s_tready[sel]=1 and m_tvalid=0. Source beats are discarded until a beat with s_tlast[sel] is accepted.
- Then rr_ptr advances unconditionally and burst_cnt clears; next state ARB_GAP (or ARB_IDLE when IFG_CYCLES=0).

General rules:
- Grant changes only in ARB_IDLE; never mid-frame.
- Counter widths: burst_cnt 4b, gap_cnt 4b, stall_cnt 8b; rr_ptr is clog2(NUM_SRC) bits and wraps from NUM_SRC-1 to 0.
- An abort is a frame end for arbitration.
- Asserting eth_rst_n low mid-frame returns to ARB_IDLE immediately. The partial frame is not terminated; the MAC reset covers it.

Optional Feature:
- ETH_TX_ARB_STATS_EN defined: adds output frame_cnt (32*NUM_SRC) and output abort_cnt (16).
  - frame_cnt[i] increments on each tlast handshake in ARB_PASS with sel=i.
  - abort_cnt increments with abort_pulse.
  - Both saturate at all-ones and clear on reset.
- Undefined: these ports and their counters do not exist.

Test Plan:
- Single source: source 1 sends a 6-beat frame, m_tready=1.
  - m_tvalid rises 1 cycle after s_tvalid[1], grant=3'b010.
  - 6 beats pass with data/keep bit-identical; tlast on beat 6.
  - Then 2 idle cycles, then ARB_IDLE.
- Fairness: all 3 sources continuously request 1-beat frames, BURST_MAX=2.
  - Grant order is 0,0,1,1,2,2,0,0…
  - Exactly IFG_CYCLES idle cycles between frames.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat source-0 frame.
  - s_tready[0] mirrors m_tready; no beat is lost or duplicated; stall_cnt stays 0.
- Stall abort: source 2 drops s_tvalid after beat 2 for 64 cycles.
  - One beat with m_tlast=1, m_tuser=1, m_tdata=0 and abort_pulse for one cycle.
  - Source 2's remaining 3 beats are drained without m_tvalid.
  - Next grant goes to source 0.
- Reset mid-frame: eth_rst_n low during beat 3.
  - All outputs go to 0 asynchronously.
  - After release, the first grant is to the lowest requesting index (rr_ptr=0).
- Stats (ETH_TX_ARB_STATS_EN): 5 frames from source 0, 3 from source 1, 1 abort.
  - frame_cnt = {0,3,5} for sources {2,1,0}; abort_cnt=1.
